imem_responder: RTL

// - Responder end of the instruction-fetch port: accepts fetch requests (byte address) from the IFU,

---
 rtl/imem_responder_pkg.sv | 41 ++++
 rtl/imem_array.sv | 38 +++
 rtl/imem_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/imem_responder_pkg.sv
// Shared types and helpers for the instruction-memory responder:
// FSM state encodings, error codes and the address check used on both ports.
package imem_responder_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_BUSY = 2'd1,
    IMEM_HOLD = 2'd2
  } imem_state_e;

  typedef enum logic [1:0] {
    IMEM_ERR_NONE  = 2'd0,
    IMEM_ERR_ALIGN = 2'd1,
    IMEM_ERR_RANGE = 2'd2
  } imem_err_e;

  // True when the byte address lies inside 0 .. depth*4-1. The limit is a
  // multiple of four, so the low two bits never change the outcome.
  function automatic logic imem_in_range(input logic [XLEN-1:0] addr,
                                         input int unsigned     depth);
    logic [XLEN+1:0] limit;
    limit = (XLEN+2)'(depth) << 2;
    return ({2'b00, addr} < limit);
  endfunction

  // Classifies a fetch address; alignment is reported ahead of range.
  function automatic imem_err_e imem_check(input logic [XLEN-1:0] addr,
                                           input int unsigned     depth);
    imem_err_e err;
    err = IMEM_ERR_NONE;
    if (addr[1:0] != 2'b00) begin
      err = IMEM_ERR_ALIGN;
    end else if (!imem_in_range(addr, depth)) begin
      err = IMEM_ERR_RANGE;
    end
    return err;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word-wide program storage: one synchronous read port and one synchronous
// write port. A read and a write to the same word on one edge return the old
// word. r_mem is filled through the loader write port by boot/bench code.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int DEPTH = 65536,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rdEn,
  input  logic [AW-1:0]   i_rdIdx,
  output logic [XLEN-1:0] o_rdData,
  input  logic            i_wrEn,
  input  logic [AW-1:0]   i_wrIdx,
  input  logic [XLEN-1:0] i_wrData
);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rdData;

  // Read register only updates on a request, so the word stays put while held.
  always_ff @(posedge i_clk) begin
    if (i_rdEn) begin
      r_rdData <= r_mem[i_rdIdx];
    end
  end

  // Loader writes; non-blocking update gives read-before-write on collisions.
  always_ff @(posedge i_clk) begin
    if (i_wrEn) begin
      r_mem[i_wrIdx] <= i_wrData;
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: one outstanding request, programmable wait
// states, response held under backpressure, flush on jump, loader write port.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH   = 65536,
  parameter int LATENCY = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_addr,
  output logic            req_ready,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [XLEN-1:0] resp_addr,
  output logic            resp_err,
  input  logic            write_mode,
  input  logic [XLEN-1:0] write_addr,
  input  logic [XLEN-1:0] write_data
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CW-1:0] LAT_LOAD = CW'(LATENCY);

  imem_state_e     r_state;
  imem_state_e     w_stateNext;
  logic [CW-1:0]   r_waitCnt;
  logic [CW-1:0]   w_cntNext;
  logic [XLEN-1:0] r_respAddr;
  logic            r_respErr;
  logic            r_dataSel;

  imem_err_e       w_reqCheck;
  logic            w_reqErr;
  logic            w_reqReady;
  logic            w_accept;
  logic            w_wrEn;
  logic [XLEN-1:0] w_rdData;

  assign w_reqCheck = imem_check(req_addr, DEPTH);
  assign w_reqErr   = (w_reqCheck != IMEM_ERR_NONE);

  // Ready depends only on state, flush and resp_ready, never on req_valid,
  // and is forced low while reset is held.
  assign w_reqReady = rst & ~flush &
                      ((r_state == IMEM_IDLE) |
                       ((r_state == IMEM_HOLD) & resp_ready));
  assign w_accept   = req_valid & w_reqReady;
  assign w_wrEn     = write_mode & imem_in_range(write_addr, DEPTH);

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk    (clk),
    .i_rdEn   (w_accept & ~w_reqErr),
    .i_rdIdx  (req_addr[AW+1:2]),
    .o_rdData (w_rdData),
    .i_wrEn   (w_wrEn),
    .i_wrIdx  (write_addr[AW+1:2]),
    .i_wrData (write_data)
  );

  // State register and wait-state counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IMEM_IDLE;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_waitCnt <= w_cntNext;
    end
  end

  // Next state: flush wins, otherwise accept / count down / wait for consume.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_waitCnt;
    if (flush) begin
      w_stateNext = IMEM_IDLE;
      w_cntNext   = '0;
    end else begin
      case (r_state)
        IMEM_IDLE: begin
          if (w_accept) begin
            w_stateNext = (LATENCY == 0) ? IMEM_HOLD : IMEM_BUSY;
            w_cntNext   = LAT_LOAD;
          end
        end
        IMEM_BUSY: begin
          if (r_waitCnt <= CW'(1)) begin
            w_stateNext = IMEM_HOLD;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_waitCnt - CW'(1);
          end
        end
        IMEM_HOLD: begin
          if (w_accept) begin
            w_stateNext = (LATENCY == 0) ? IMEM_HOLD : IMEM_BUSY;
            w_cntNext   = LAT_LOAD;
          end else if (resp_ready) begin
            w_stateNext = IMEM_IDLE;
          end
        end
        default: begin
          w_stateNext = IMEM_IDLE;
          w_cntNext   = '0;
        end
      endcase
    end
  end

  // Response tag captured at accept; the data word comes from the array read register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_respAddr <= '0;
      r_respErr  <= 1'b0;
      r_dataSel  <= 1'b0;
    end else if (w_accept) begin
      r_respAddr <= req_addr;
      r_respErr  <= w_reqErr;
      r_dataSel  <= ~w_reqErr;
    end
  end

  assign req_ready  = w_reqReady;
  assign resp_valid = (r_state == IMEM_HOLD);
  assign resp_data  = r_dataSel ? w_rdData : '0;
  assign resp_addr  = r_respAddr;
  assign resp_err   = r_respErr;

endmodule
